// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection.
//
// Captures the decoded instruction bundle on each rising edge and presents it,
// registered, to the execute stage and the ALU controller. A bubble (all ex_*
// fields zero, so the ALU controller sees ADD and no side effects occur) is
// inserted on a branch/jump flush or on a load-use hazard. The stage holds
// while stall_ext is high.
//
// Optional feature: define ID_EX_HAZARD_STATS_EN to enable the saturating
// stall_cnt / flush_cnt statistics counters. When it is undefined, both
// outputs are tied to zero and no counter flops exist.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   id_valid              decode slot holds a real instruction
//   id_pc/rd1/rd2/imm     XLEN-wide PC, operands and sign-extended immediate
//   id_rs1/rs2/rd         register indices
//   id_funct3/funct7      instruction function fields
//   id_aluop              ALU operation class
//   id_ctrl               {alusrc, memread, memwrite, regwrite, memtoreg, branch, jump}
//   flush_ex              kill younger instructions (branch/jump taken in EX)
//   stall_ext             downstream busy; freeze the stage
//   ex_*                  registered copies of the id_* fields
//   hold_if_id            combinational: freeze PC and IF/ID this cycle
//   stall_cnt, flush_cnt  hazard statistics (zero unless the feature is enabled)
module id_ex_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_rd1,
   input  logic [XLEN-1:0]  id_rd2,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic [2:0]       id_funct3,
   input  logic [6:0]       id_funct7,
   input  logic [1:0]       id_aluop,
   input  logic [6:0]       id_ctrl,
   input  logic             flush_ex,
   input  logic             stall_ext,
   output logic             ex_valid,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_rd1,
   output logic [XLEN-1:0]  ex_rd2,
   output logic [XLEN-1:0]  ex_imm,
   output logic [4:0]       ex_rs1,
   output logic [4:0]       ex_rs2,
   output logic [4:0]       ex_rd,
   output logic [2:0]       ex_funct3,
   output logic [6:0]       ex_funct7,
   output logic [1:0]       ex_aluop,
   output logic [6:0]       ex_ctrl,
   output logic             hold_if_id,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // Position of memread inside the control bundle.
   localparam int unsigned MEMREAD_BIT = 5;

   logic load_use;
   logic bubble;

   // A load in EX whose destination is read by the instruction in ID.
   always_comb begin
      load_use = id_valid & ex_valid & ex_ctrl[MEMREAD_BIT] & (ex_rd != 5'd0) &
                 ((ex_rd == id_rs1) | (ex_rd == id_rs2)) & ~flush_ex;
   end

   // ex_valid is already 0 in reset, but stall_ext must also be masked there.
   assign hold_if_id = rst_n & (load_use | stall_ext);

   // Flush beats stall; stall beats the load-use bubble.
   assign bubble = flush_ex | (load_use & ~stall_ext);

   // Pipeline register: bubble, hold, or load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid  <= 1'b0;
         ex_pc     <= '0;
         ex_rd1    <= '0;
         ex_rd2    <= '0;
         ex_imm    <= '0;
         ex_rs1    <= '0;
         ex_rs2    <= '0;
         ex_rd     <= '0;
         ex_funct3 <= '0;
         ex_funct7 <= '0;
         ex_aluop  <= '0;
         ex_ctrl   <= '0;
      end else if (bubble) begin
         ex_valid  <= 1'b0;
         ex_pc     <= '0;
         ex_rd1    <= '0;
         ex_rd2    <= '0;
         ex_imm    <= '0;
         ex_rs1    <= '0;
         ex_rs2    <= '0;
         ex_rd     <= '0;
         ex_funct3 <= '0;
         ex_funct7 <= '0;
         ex_aluop  <= '0;
         ex_ctrl   <= '0;
      end else if (!stall_ext) begin
         ex_valid  <= id_valid;
         ex_pc     <= id_pc;
         ex_rd1    <= id_rd1;
         ex_rd2    <= id_rd2;
         ex_imm    <= id_imm;
         ex_rs1    <= id_rs1;
         ex_rs2    <= id_rs2;
         ex_rd     <= id_rd;
         ex_funct3 <= id_funct3;
         ex_funct7 <= id_funct7;
         ex_aluop  <= id_aluop;
         // An invalid slot must never cause a side effect downstream.
         ex_ctrl   <= id_valid ? id_ctrl : 7'd0;
      end
   end

`ifdef ID_EX_HAZARD_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] flush_q;

   // Saturating hazard statistics.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (load_use && !stall_ext && (stall_q != CNT_MAX)) begin
            stall_q <= stall_q + CNT_W'(1);
         end
         if (flush_ex && (flush_q != CNT_MAX)) begin
            flush_q <= flush_q + CNT_W'(1);
         end
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between instruction decode and execute, with load-use hazard detection.
- Captures the decoded control/operand bundle each cycle and presents it registered to execute.
- Outputs ex_aluop, ex_funct3 and ex_funct7 feed the ALU controller directly.
- Inserts bubbles on load-use hazards, holds on external stall, clears on branch/jump flush.

Parameters:
- XLEN, 32, datapath width of pc, operands and immediate.
- CNT_W, 16, width of the hazard statistics counters (optional feature only).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  XLEN  instruction PC
- id_rd1  in  XLEN  register-file read data, rs1
- id_rd2  in  XLEN  register-file read data, rs2
- id_imm  in  XLEN  sign-extended immediate
- id_rs1  in  5  source register index 1
- id_rs2  in  5  source register index 2
- id_rd  in  5  destination register index
- id_funct3  in  3  instr[14:12]
- id_funct7  in  7  instr[31:25]
- id_aluop  in  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI
- id_ctrl  in  7  {alusrc, memread, memwrite, regwrite, memtoreg, branch, jump}
- flush_ex  in  1  branch/jump taken in EX; kill younger instructions
- stall_ext  in  1  downstream busy (e.g. data memory); freeze the stage
- ex_valid  out  1  registered id_valid
- ex_pc, ex_rd1, ex_rd2, ex_imm  out  XLEN  registered data
- ex_rs1, ex_rs2, ex_rd  out  5  registered indices
- ex_funct3  out  3  to ALU controller
- ex_funct7  out  7  to ALU controller
- ex_aluop  out  2  to ALU controller
- ex_ctrl  out  7  registered control bundle, same bit order as id_ctrl
- hold_if_id  out  1  freeze PC and the IF/ID register this cycle
- stall_cnt  out  CNT_W  load-use bubble count (optional feature)
- flush_cnt  out  CNT_W  flush count (optional feature)

Behaviour:
Reset:
- rst_n low asynchronously clears every ex_* output to 0, giving ex_valid=0 and ex_aluop=00.
- Counters are also cleared.
- hold_if_id is combinational; it is 0 while in reset.

Load-use detection (combinational):
- load_use = id_valid & ex_valid & ex_ctrl.memread & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)) & ~flush_ex.
- hold_if_id = load_use | stall_ext.

Per-edge update, highest priority first:
1. flush_ex=1: load a bubble, i.e. all ex_* fields 0. Flush overrides stall_ext.
2. stall_ext=1: hold every ex_* field unchanged.
3. load_use=1: load a bubble. The ID instruction is re-presented next cycle because hold_if_id=1.
4. Otherwise: load all id_* fields; ex_valid takes id_valid.

Bubble and invalid-instruction rules:
- A bubble has ex_ctrl=0 and ex_aluop=00, so the ALU controller sees ADD and no memory or register-file side effect occurs.
- id_valid=0 with no other condition loads id_* as presented, with ex_valid=0. In addition, ex_ctrl is forced to 0 so an invalid slot never writes.

Latency and boundary conditions:
- Latency is exactly 1 cycle from ID inputs to ex_* outputs; no combinational path exists from id_* to ex_*.
- Back-to-back loads with a dependent third instruction insert exactly one bubble per dependency.
- After a bubble, ex_valid=0, so the re-presented instruction cannot trigger a second hazard.
- stall_ext together with load_use: hold wins and no bubble is inserted. The hazard re-evaluates once stall_ext drops.
- rd=x0 never causes a hazard.
- Reset deasserting mid-stream: the first edge after release loads normally.

Optional Feature:
- Macro: ID_EX_HAZARD_STATS_EN.
- When defined:
  - stall_cnt increments on each edge where load_use=1 and stall_ext=0.
  - flush_cnt increments on each edge where flush_ex=1.
  - Both counters saturate at 2^CNT_W-1 and clear on reset.
- When undefined: stall_cnt and flush_cnt are tied to 0, with no counter flops.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle with ex_valid=1 -> all ex_* become 0 immediately, without waiting for a clock edge. hold_if_id=0.
2. Passthrough: id_aluop=10, funct3=000, funct7=0100000 (sub), id_rd1=5, id_rd2=3, id_valid=1 -> next edge shows ex_aluop=10, ex_funct7=0100000, ex_rd1=5, ex_valid=1.
3. Load-use: EX holds lw x5 (memread=1, rd=5); ID holds add x6,x5,x1 ->
   - hold_if_id=1;
   - next edge ex_valid=0 and ex_ctrl=0;
   - the following edge loads the add with ex_rs1=5.
4. No false hazard:
   - lw x0 followed by a use of x0 -> no stall;
   - EX holds a non-load writing x5, followed by a use of x5 -> no stall.
5. Flush priority: flush_ex=1 and stall_ext=1 on the same edge with a valid ID instruction -> ex_valid=0; ex_ctrl=0; flush_cnt=1 if ID_EX_HAZARD_STATS_EN is defined.
6. External stall: stall_ext=1 for 3 cycles while id_* change -> ex_* remain constant and hold_if_id=1. On release the current id_* are loaded.
